// File: rtl/spi_device_ctrl_ml.sv
// Multi-lane SPI device command sequencer: decodes commands, sequences address/dummy/data
// phases for the shift front-end and drives word transfers to the on-chip bus bridge.
module spi_device_ctrl_ml #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DEFAULT_DUMMY = 32,
    parameter int unsigned WRAP_WIDTH    = 16
) (
    input  logic                  sclk,
    input  logic                  sys_rstn,
    input  logic                  cs,
    output logic [1:0]            lane_mode,
    output logic                  pad_dir,
    output logic [7:0]            rx_counter,
    output logic                  rx_counter_upd,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_data_valid,
    output logic [7:0]            tx_counter,
    output logic                  tx_counter_upd,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_data_valid,
    input  logic                  tx_done,
    output logic                  ctrl_rd_wr,
    output logic [ADDR_WIDTH-1:0] ctrl_addr,
    output logic                  ctrl_addr_valid,
    output logic [DATA_WIDTH-1:0] ctrl_data_rx,
    output logic                  ctrl_data_rx_valid,
    input  logic                  ctrl_data_rx_ready,
    input  logic [DATA_WIDTH-1:0] ctrl_data_tx,
    input  logic                  ctrl_data_tx_valid,
    output logic                  ctrl_data_tx_ready,
    output logic [7:0]            dummy_cycles,
    output logic [WRAP_WIDTH-1:0] wrap_length,
    output logic                  err_overflow,
    output logic                  err_underflow,
    output logic                  err_cmd
);

    typedef enum logic [2:0] {
        StCmd, StAddr, StDummy, StDataRx, StDataTx, StRegRx, StRegTx, StError
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(DATA_WIDTH / 8);

    function automatic logic [7:0] phase_cnt(input int unsigned bits, input logic [1:0] mode);
        int unsigned per_lane;
        case (mode)
            2'b01:   per_lane = bits >> 1;
            2'b10:   per_lane = bits >> 2;
            default: per_lane = bits;
        endcase
        return 8'(per_lane - 1);
    endfunction

    state_e                state_q, state_d;
    logic [1:0]            lane_q, lane_d, reg_idx_q, reg_idx_d;
    logic [7:0]            dummy_q, dummy_d, wrap_lo_q, wrap_lo_d, wrap_hi_q, wrap_hi_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d, cmd_err_q, cmd_err_d;
    logic                  rd_q, rd_d, bus_load_q, bus_load_d, tx_valid_q, tx_valid_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
    logic [WRAP_WIDTH-1:0] word_q, word_d, word_nxt;
    logic [7:0]            tx_cnt_q, tx_cnt_d, cmd, reg_rd_val;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [15:0]           wrap_full;
    logic                  rx_fire, addr_pulse, wr_pulse, read_req;

    assign cmd       = rx_data[7:0];
    assign wrap_full = {wrap_hi_q, wrap_lo_q};
    assign word_nxt  = word_q + 1'b1;
    assign rx_fire   = rx_data_valid && !cs &&
                       (state_q inside {StCmd, StAddr, StDummy, StDataRx, StRegRx});

    always_comb begin
        case (cmd[1:0])
            2'd0:    reg_rd_val = {ovf_q, unf_q, cmd_err_q, 3'b000, lane_q};
            2'd1:    reg_rd_val = dummy_q;
            2'd2:    reg_rd_val = wrap_lo_q;
            default: reg_rd_val = wrap_hi_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        reg_idx_d  = reg_idx_q;
        dummy_d    = dummy_q;
        wrap_lo_d  = wrap_lo_q;
        wrap_hi_d  = wrap_hi_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        cmd_err_d  = cmd_err_q;
        rd_d       = rd_q;
        base_d     = base_q;
        addr_d     = addr_q;
        word_d     = word_q;
        tx_cnt_d   = tx_cnt_q;
        tx_data_d  = tx_data_q;
        bus_load_d = 1'b0;
        tx_valid_d = 1'b0;
        addr_pulse = 1'b0;
        wr_pulse   = 1'b0;
        read_req   = 1'b0;

        // Freeze whatever the load cycle presented so tx_data holds it while shifting.
        if (bus_load_q) begin
            tx_data_d = tx_data;
            if (!ctrl_data_tx_valid) unf_d = 1'b1;
        end

        if (cs) begin
            state_d = StCmd;
            word_d  = '0;
        end else begin
            case (state_q)
                StCmd: if (rx_data_valid) begin
                    if (cmd == 8'h02 || cmd == 8'h0B) begin
                        state_d = StAddr;
                        rd_d    = (cmd == 8'h0B);
                    end else if (cmd[7:2] == 6'b000100) begin
                        state_d   = StRegRx;
                        reg_idx_d = cmd[1:0];
                    end else if (cmd[7:2] == 6'b001000) begin
                        state_d    = StRegTx;
                        tx_data_d  = DATA_WIDTH'(reg_rd_val);
                        tx_valid_d = 1'b1;
                        tx_cnt_d   = phase_cnt(32'd8, lane_q);
                        if (cmd[1:0] == 2'd0) begin
                            ovf_d     = 1'b0;
                            unf_d     = 1'b0;
                            cmd_err_d = 1'b0;
                        end
                    end else begin
                        state_d   = StError;
                        cmd_err_d = 1'b1;
                    end
                end
                StAddr: if (rx_data_valid) begin
                    base_d  = rx_data[ADDR_WIDTH-1:0];
                    addr_d  = rx_data[ADDR_WIDTH-1:0];
                    word_d  = '0;
                    state_d = rd_q ? StDummy : StDataRx;
                end
                StDummy: if (rx_data_valid) begin
                    state_d  = StDataTx;
                    read_req = 1'b1;
                end
                StDataRx: if (rx_data_valid) begin
                    if (ctrl_data_rx_ready) begin
                        addr_pulse = 1'b1;
                        wr_pulse   = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (wrap_length != '0 && word_nxt == wrap_length) begin
                        word_d = '0;
                        addr_d = base_q;
                    end else begin
                        word_d = word_nxt;
                        addr_d = addr_q + AddrStep;
                    end
                end
                StDataTx: if (tx_done) read_req = 1'b1;
                StRegRx: if (rx_data_valid) begin
                    case (reg_idx_q)
                        2'd0:    lane_d    = cmd[1:0];
                        2'd1:    dummy_d   = cmd;
                        2'd2:    wrap_lo_d = cmd;
                        default: wrap_hi_d = cmd;
                    endcase
                    state_d = StCmd;
                end
                StRegTx: if (tx_done) state_d = StCmd;
                default: ;
            endcase
        end

        if (read_req) begin
            addr_pulse = 1'b1;
            bus_load_d = 1'b1;
            tx_valid_d = 1'b1;
            tx_cnt_d   = phase_cnt(DATA_WIDTH, lane_q);
            if (wrap_length != '0 && word_nxt == wrap_length) begin
                word_d = '0;
                addr_d = base_q;
            end else begin
                word_d = word_nxt;
                addr_d = addr_q + AddrStep;
            end
        end
        if (state_d == StCmd) rd_d = 1'b0;
    end

    // The counter for the phase being entered; lane_d lets a lane write apply on return to CMD.
    always_comb begin
        case (state_d)
            StAddr:   rx_counter = phase_cnt(ADDR_WIDTH, lane_d);
            StDummy:  rx_counter = dummy_q - 8'd1;
            StDataRx: rx_counter = phase_cnt(DATA_WIDTH, lane_d);
            default:  rx_counter = phase_cnt(32'd8, lane_d);
        endcase
        rx_counter_upd = rx_fire && !(state_d inside {StDataTx, StRegTx, StError});
    end

    always_ff @(posedge sclk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q    <= StCmd;
            lane_q     <= 2'b00;
            reg_idx_q  <= 2'b00;
            dummy_q    <= 8'(DEFAULT_DUMMY);
            wrap_lo_q  <= 8'h00;
            wrap_hi_q  <= 8'h00;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            cmd_err_q  <= 1'b0;
            rd_q       <= 1'b0;
            bus_load_q <= 1'b0;
            tx_valid_q <= 1'b0;
            base_q     <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            tx_cnt_q   <= 8'h00;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            reg_idx_q  <= reg_idx_d;
            dummy_q    <= dummy_d;
            wrap_lo_q  <= wrap_lo_d;
            wrap_hi_q  <= wrap_hi_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            cmd_err_q  <= cmd_err_d;
            rd_q       <= rd_d;
            bus_load_q <= bus_load_d;
            tx_valid_q <= tx_valid_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign lane_mode          = lane_q;
    assign pad_dir            = (state_q == StDataTx) || (state_q == StRegTx);
    assign tx_counter         = tx_cnt_q;
    assign tx_counter_upd     = tx_valid_q;
    assign tx_data_valid      = tx_valid_q;
    assign tx_data            = bus_load_q ? (ctrl_data_tx_valid ? ctrl_data_tx : '1) : tx_data_q;
    assign ctrl_rd_wr         = rd_q;
    assign ctrl_addr          = addr_q;
    assign ctrl_addr_valid    = addr_pulse;
    assign ctrl_data_rx       = rx_data;
    assign ctrl_data_rx_valid = wr_pulse;
    assign ctrl_data_tx_ready = bus_load_q && ctrl_data_tx_valid;
    assign dummy_cycles       = dummy_q;
    assign wrap_length        = wrap_full[WRAP_WIDTH-1:0];
    assign err_overflow       = ovf_q;
    assign err_underflow      = unf_q;
    assign err_cmd            = cmd_err_q;

endmodule
